// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the reservation station.
// Optional oldest-first issue is enabled with RS_OLDEST_FIRST_EN.
package reservation_station_pkg;

  localparam int unsigned RsSizeDefault = 16;
  localparam int unsigned DataW         = 32;
  localparam int unsigned AddrW         = 32;
  localparam int unsigned RobIdW        = 5;

  typedef enum logic [3:0] {
    OpReset = 4'd0,
    OpAdd,
    OpAddi,
    OpSub,
    OpAnd,
    OpOr,
    OpXor,
    OpLui
  } op_enum_t;

  typedef logic [DataW-1:0]  data_t;
  typedef logic [AddrW-1:0]  addr_t;
  typedef logic [RobIdW-1:0] rob_id_t;

  localparam data_t DataReset = '0;
  localparam addr_t AddrReset = '0;

  typedef struct packed {
    logic    valid;
    rob_id_t rob_id;
    data_t   result;
  } cdb_t;

  typedef struct packed {
    logic    pend;
    rob_id_t q;
    data_t   v;
  } operand_t;

  typedef struct packed {
    op_enum_t op;
    operand_t src1;
    operand_t src2;
    data_t    imm;
    addr_t    inst_pos;
    rob_id_t  rob_id;
  } rs_entry_t;

  typedef struct packed {
    op_enum_t op;
    data_t    v1;
    data_t    v2;
    data_t    imm;
    addr_t    inst_pos;
    rob_id_t  rob_id;
  } issue_t;

  localparam issue_t IssueReset = '{
    op: OpReset, v1: DataReset, v2: DataReset, imm: DataReset, inst_pos: AddrReset, rob_id: '0
  };

  // Captures a pending operand from either broadcast bus; lsb wins a (degenerate) double hit.
  function automatic operand_t snoop(input operand_t opnd, input cdb_t a, input cdb_t b);
    operand_t res;
    res = opnd;
    if (opnd.pend && a.valid && a.rob_id == opnd.q) begin
      res.v    = a.result;
      res.pend = 1'b0;
    end
    if (opnd.pend && b.valid && b.rob_id == opnd.q) begin
      res.v    = b.result;
      res.pend = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_rs_select.sv
// Priority encoders: lowest free slot for dispatch, ready slot for issue.
// With RS_OLDEST_FIRST_EN the issue pick is the largest age, ties to lowest index.
module rs_select #(
  parameter int unsigned N    = 16,
  parameter int unsigned IdxW = $clog2(N)
`ifdef RS_OLDEST_FIRST_EN
  ,
  parameter int unsigned AgeW = IdxW + 1
`endif
) (
  input  logic [N-1:0]            free_vec_i,
  input  logic [N-1:0]            ready_vec_i,
`ifdef RS_OLDEST_FIRST_EN
  input  logic [N-1:0][AgeW-1:0]  age_i,
`endif
  output logic                    free_found_o,
  output logic [IdxW-1:0]         free_idx_o,
  output logic                    issue_found_o,
  output logic [IdxW-1:0]         issue_idx_o
);

  always_comb begin
    free_found_o = 1'b0;
    free_idx_o   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (free_vec_i[i]) begin
        free_found_o = 1'b1;
        free_idx_o   = IdxW'(i);
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  logic [AgeW-1:0] best_age;

  always_comb begin
    issue_found_o = 1'b0;
    issue_idx_o   = '0;
    best_age      = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (ready_vec_i[i] && (!issue_found_o || age_i[i] > best_age)) begin
        issue_found_o = 1'b1;
        issue_idx_o   = IdxW'(i);
        best_age      = age_i[i];
      end
    end
  end
`else
  always_comb begin
    issue_found_o = 1'b0;
    issue_idx_o   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (ready_vec_i[i]) begin
        issue_found_o = 1'b1;
        issue_idx_o   = IdxW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/reservation_station.sv
// Reservation station: dispatch with CDB bypass, wakeup, single issue per cycle.
// Define RS_OLDEST_FIRST_EN for age-based issue; default issues the lowest ready index.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE = RsSizeDefault
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     clear_in,
  input  logic     disp_valid,
  input  op_enum_t disp_op_enum,
  input  data_t    disp_V1,
  input  data_t    disp_V2,
  input  rob_id_t  disp_Q1,
  input  rob_id_t  disp_Q2,
  input  logic     disp_Q1_valid,
  input  logic     disp_Q2_valid,
  input  data_t    disp_imm,
  input  addr_t    disp_inst_pos,
  input  rob_id_t  disp_rob_id,
  output logic     rs_full,
  input  logic     alu_cdb_valid,
  input  rob_id_t  alu_cdb_rob_id,
  input  data_t    alu_cdb_result,
  input  logic     lsb_cdb_valid,
  input  rob_id_t  lsb_cdb_rob_id,
  input  data_t    lsb_cdb_result,
  output op_enum_t alu_op_enum,
  output data_t    alu_V1,
  output data_t    alu_V2,
  output data_t    alu_imm,
  output addr_t    alu_inst_pos,
  output rob_id_t  alu_rob_id
);

  localparam int unsigned IdxW = $clog2(RS_SIZE);

  rs_entry_t            entry_q [RS_SIZE];
  rs_entry_t            entry_d [RS_SIZE];
  logic [RS_SIZE-1:0]   busy_q, busy_d, ready;
  issue_t               alu_q, alu_d;
  cdb_t                 alu_cdb, lsb_cdb;
  logic                 free_found, issue_found;
  logic [IdxW-1:0]      free_idx, issue_idx;

`ifdef RS_OLDEST_FIRST_EN
  localparam int unsigned AgeW = IdxW + 1;
  logic [RS_SIZE-1:0][AgeW-1:0] age_q, age_d;
`endif

  assign alu_cdb = '{valid: alu_cdb_valid, rob_id: alu_cdb_rob_id, result: alu_cdb_result};
  assign lsb_cdb = '{valid: lsb_cdb_valid, rob_id: lsb_cdb_rob_id, result: lsb_cdb_result};
  assign rs_full = &busy_q;

  always_comb begin
    ready = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      ready[i] = busy_q[i] && !entry_q[i].src1.pend && !entry_q[i].src2.pend;
    end
  end

  rs_select #(
    .N    (RS_SIZE),
    .IdxW (IdxW)
`ifdef RS_OLDEST_FIRST_EN
    ,
    .AgeW (AgeW)
`endif
  ) u_select (
    .free_vec_i    (~busy_q),
    .ready_vec_i   (ready),
`ifdef RS_OLDEST_FIRST_EN
    .age_i         (age_q),
`endif
    .free_found_o  (free_found),
    .free_idx_o    (free_idx),
    .issue_found_o (issue_found),
    .issue_idx_o   (issue_idx)
  );

  always_comb begin
    entry_d = entry_q;
    busy_d  = busy_q;
    alu_d   = alu_q;
`ifdef RS_OLDEST_FIRST_EN
    age_d   = age_q;
`endif
    if (rdy_in) begin
      if (clear_in) begin
        busy_d = '0;
        alu_d  = IssueReset;
`ifdef RS_OLDEST_FIRST_EN
        age_d  = '0;
`endif
      end else begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          if (busy_q[i]) begin
            entry_d[i].src1 = snoop(entry_q[i].src1, alu_cdb, lsb_cdb);
            entry_d[i].src2 = snoop(entry_q[i].src2, alu_cdb, lsb_cdb);
          end
        end
        alu_d = IssueReset;
        if (issue_found) begin
          busy_d[issue_idx] = 1'b0;
          alu_d = '{op: entry_q[issue_idx].op, v1: entry_q[issue_idx].src1.v,
                    v2: entry_q[issue_idx].src2.v, imm: entry_q[issue_idx].imm,
                    inst_pos: entry_q[issue_idx].inst_pos, rob_id: entry_q[issue_idx].rob_id};
        end
        // Full is judged on stored state, so a same-edge issue never admits a dispatch.
        if (disp_valid && !rs_full && free_found) begin
          busy_d[free_idx]  = 1'b1;
          entry_d[free_idx] = '{
            op:       disp_op_enum,
            src1:     snoop('{pend: disp_Q1_valid, q: disp_Q1, v: disp_V1}, alu_cdb, lsb_cdb),
            src2:     snoop('{pend: disp_Q2_valid, q: disp_Q2, v: disp_V2}, alu_cdb, lsb_cdb),
            imm:      disp_imm,
            inst_pos: disp_inst_pos,
            rob_id:   disp_rob_id
          };
`ifdef RS_OLDEST_FIRST_EN
          for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (busy_q[i] && age_q[i] != '1) age_d[i] = age_q[i] + 1'b1;
          end
          age_d[free_idx] = '0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      alu_q  <= IssueReset;
`ifdef RS_OLDEST_FIRST_EN
      age_q  <= '0;
`endif
    end else begin
      busy_q  <= busy_d;
      entry_q <= entry_d;
      alu_q   <= alu_d;
`ifdef RS_OLDEST_FIRST_EN
      age_q   <= age_d;
`endif
    end
  end

  assign alu_op_enum  = alu_q.op;
  assign alu_V1       = alu_q.v1;
  assign alu_V2       = alu_q.v2;
  assign alu_imm      = alu_q.imm;
  assign alu_inst_pos = alu_q.inst_pos;
  assign alu_rob_id   = alu_q.rob_id;

endmodule
